// File: rtl/high_speed_bus_ecc_pkg.sv
// Shared SECDED layout for the high_speed_bus_ecc encoder/decoder pair.
// The encoder and the decoder both import this package, so the codeword layout is identical on each side.
package high_speed_bus_ecc_pkg;

  localparam int DATA_W      = 32;
  localparam int CHK_W       = 7;
  localparam int CW_W        = 39;
  localparam int HAM_POS_MAX = 38;
  localparam int SYN_W       = 6;

  // Hamming position (1-based) of each data bit; powers of two hold check bits.
  localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                p;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      p    = int'(DATA_POS[i]) - 1;
      d[i] = cw[p];
    end
    return d;
  endfunction

endpackage

// File: rtl/high_speed_bus_ecc_decoder_ecc_syndrome_calc.sv
// Combinational syndrome/parity of a 39-bit SECDED codeword.
// The encoder bench also uses this module.
module ecc_syndrome_calc
  import high_speed_bus_ecc_pkg::*;
(
  input  logic [CW_W-1:0]  codeword,
  output logic [SYN_W-1:0] syndrome,
  output logic             parity
);

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < HAM_POS_MAX; i++) begin
      if (codeword[i]) syndrome = syndrome ^ SYN_W'(i + 1);
    end
  end

  assign parity = ^codeword;

endmodule

// File: rtl/high_speed_bus_ecc_decoder.sv
// Two-stage SECDED decoder: S1 captures codeword+syndrome+parity, S2 holds corrected data and flags.
// Optional error statistics are built when ECC_STATS_EN is defined.
module high_speed_bus_ecc_decoder
  import high_speed_bus_ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              corrected,
  output logic              uncorrectable,
  output logic [SYN_W-1:0]  syndrome,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count
);

  // Handshake: a word moves on a rising edge where valid && ready; the whole pipe
  // advances together when the output register is empty or being drained (adv).
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [SYN_W-1:0] in_syn;
  logic             in_par;

  ecc_syndrome_calc u_syn (
    .codeword (codeword_in),
    .syndrome (in_syn),
    .parity   (in_par)
  );

  logic             s1_valid;
  logic [CW_W-1:0]  s1_cw;
  logic [SYN_W-1:0] s1_syn;
  logic             s1_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s1_cw  <= codeword_in;
      s1_syn <= in_syn;
      s1_par <= in_par;
    end
  end

  logic [CW_W-1:0]   fix_cw;
  logic [DATA_W-1:0] fix_data;
  logic              fix_ce;
  logic              fix_ue;

  // Odd parity means one flipped bit: syndrome 0 points at the overall parity bit,
  // 1..38 at a codeword position, anything larger cannot be a single error.
  always_comb begin
    fix_cw = s1_cw;
    fix_ce = 1'b0;
    fix_ue = 1'b0;
    if (s1_par) begin
      if (s1_syn <= SYN_W'(HAM_POS_MAX)) fix_ce = 1'b1;
      else                               fix_ue = 1'b1;
    end else if (s1_syn != '0) begin
      fix_ue = 1'b1;
    end
    if (fix_ce) begin
      for (int i = 0; i < HAM_POS_MAX; i++) begin
        if (s1_syn == SYN_W'(i + 1)) fix_cw[i] = ~s1_cw[i];
      end
    end
    fix_data = extract_data(fix_cw);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
      syndrome      <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= fix_data;
        corrected     <= fix_ce;
        uncorrectable <= fix_ue;
        syndrome      <= s1_syn;
      end
    end
  end

`ifdef ECC_STATS_EN
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (out_fire) begin
      if (corrected && (ce_count != '1))     ce_count <= ce_count + 1'b1;
      if (uncorrectable && (ue_count != '1)) ue_count <= ue_count + 1'b1;
    end
  end
`else
  logic unused_clear_counts;
  assign unused_clear_counts = clear_counts;
  assign ce_count = '0;
  assign ue_count = '0;
`endif

endmodule

// File: tb/tb_high_speed_bus_ecc_decoder.sv
// Directed scoreboard bench for high_speed_bus_ecc_decoder; counter checks follow ECC_STATS_EN.
module tb_high_speed_bus_ecc_decoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [38:0]      codeword_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      data_out;
  logic             corrected;
  logic             uncorrectable;
  logic [5:0]       syndrome;
  logic             clear_counts;
  logic [CNT_W-1:0] ce_count;
  logic [CNT_W-1:0] ue_count;

  high_speed_bus_ecc_decoder #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .codeword_in   (codeword_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .corrected     (corrected),
    .uncorrectable (uncorrectable),
    .syndrome      (syndrome),
    .clear_counts  (clear_counts),
    .ce_count      (ce_count),
    .ue_count      (ue_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [39:0] exp_q[$];

  function automatic logic [39:0] pk(logic [31:0] d, logic c, logic u, logic [5:0] s);
    return {d, c, u, s};
  endfunction

  // Reference SECDED encoder built directly from the layout description.
  function automatic logic [38:0] enc(logic [31:0] d);
    logic [38:0] cw;
    logic        par;
    int          di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[di];
        di++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 38; pos++) begin
        if ((pos & (1 << k)) != 0) par = par ^ cw[pos-1];
      end
      cw[(1 << k) - 1] = par;
    end
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [38:0] cw, input logic [39:0] e, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = cw;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    #2;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall;
  logic [40:0] prev_snap;

  initial begin
    logic [39:0] e;
    logic [40:0] snap;
    prev_stall = 1'b0;
    prev_snap  = '0;
    forever begin
      @(negedge clk);
      #2;
      snap = {out_valid, data_out, corrected, uncorrectable, syndrome};
      if (!reset) begin
        if (prev_stall) chk("stall_hold", 64'(snap), 64'(prev_snap));
        if (out_valid && out_ready) begin
          n_out++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out: got data=%h c=%b u=%b syn=%0d, expected no word",
                     data_out, corrected, uncorrectable, syndrome);
          end else begin
            e = exp_q.pop_front();
            if ({data_out, corrected, uncorrectable, syndrome} !== e) begin
              n_bad++;
              $display("FAIL out_word: got data=%h c=%b u=%b syn=%0d, expected data=%h c=%b u=%b syn=%0d",
                       data_out, corrected, uncorrectable, syndrome,
                       e[39:8], e[7], e[6], e[5:0]);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_snap  = snap;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int out_before;
    reset        = 1'b1;
    in_valid     = 1'b0;
    codeword_in  = '0;
    out_ready    = 1'b1;
    clear_counts = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_corrected", 64'(corrected), 64'd0);
    chk("rst_uncorrectable", 64'(uncorrectable), 64'd0);
    chk("rst_syndrome", 64'(syndrome), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ce_count", 64'(ce_count), 64'd0);
    chk("rst_ue_count", 64'(ue_count), 64'd0);

    // Directed single words (hand-derived syndromes).
    send(enc(32'hA5A5A5A5),                      pk(32'hA5A5A5A5, 1'b0, 1'b0, 6'd0),  1);
    send(enc(32'hDEADBEEF) ^ 39'h4,              pk(32'hDEADBEEF, 1'b1, 1'b0, 6'd3),  1);
    send(enc(32'h12345678) ^ (39'h1 << 38),      pk(32'h12345678, 1'b1, 1'b0, 6'd0),  1);
    send(enc(32'hCAFEBABE) ^ 39'h14,             pk(32'hCAFEBABD, 1'b0, 1'b1, 6'd6),  1);
    send(enc(32'h00000000) ^ (39'h1 << 37),      pk(32'h00000000, 1'b1, 1'b0, 6'd38), 1);
    send(enc(32'hFFFFFFFF) ^ (39'h1 << 31),      pk(32'hFFFFFFFF, 1'b1, 1'b0, 6'd32), 1);
    send(enc(32'h00000000) ^ (39'h7 << 35),      pk(32'hE0000000, 1'b0, 1'b1, 6'd39), 1);
    send(enc(32'h55555555) ^ ((39'h1 << 38) | 39'h4),
                                                 pk(32'h55555554, 1'b0, 1'b1, 6'd3),  1);
    idle();
    drain("drain_directed");

    // Stream of 10 clean words with a 3-cycle output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(enc(32'h10000000 + 32'(i) * 32'h01010101),
               pk(32'h10000000 + 32'(i) * 32'h01010101, 1'b0, 1'b0, 6'd0), 1);
        end
        idle();
      end
      begin
        repeat (5) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          if (j != 0) @(negedge clk);
          out_ready = 1'b0;
          #1;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");

`ifdef ECC_STATS_EN
    @(negedge clk);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    #2;
    chk("clr_ce_count", 64'(ce_count), 64'd0);
    chk("clr_ue_count", 64'(ue_count), 64'd0);
`endif

    // 17 single-bit errors at varying positions.
    for (int i = 0; i < 17; i++) begin
      send(enc(32'h3C000000 ^ 32'(i * 7)) ^ (39'h1 << (i * 2)),
           pk(32'h3C000000 ^ 32'(i * 7), 1'b1, 1'b0, 6'(i * 2 + 1)), 1);
    end
    send(enc(32'h0F0F0F0F) ^ 39'h3, pk(32'h0F0F0F0F, 1'b0, 1'b1, 6'd3), 1);
    send(enc(32'hF0F0F0F0) ^ 39'h3, pk(32'hF0F0F0F0, 1'b0, 1'b1, 6'd3), 1);
    idle();
    drain("drain_errors");
`ifdef ECC_STATS_EN
    chk("sat_ce_count", 64'(ce_count), 64'hF);
    chk("ue_count_two", 64'(ue_count), 64'd2);
`else
    chk("tied_ce_count", 64'(ce_count), 64'd0);
    chk("tied_ue_count", 64'(ue_count), 64'd0);
`endif

    // Clear and a corrected-word handshake in the same cycle: clear wins.
    @(negedge clk);
    out_ready = 1'b0;
    send(enc(32'h00C0FFEE) ^ 39'h10, pk(32'h00C0FFEE, 1'b1, 1'b0, 6'd5), 1);
    idle();
    @(negedge clk);
    #2;
    chk("held_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    clear_counts = 1'b1;
    out_ready    = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    #2;
    chk("clr_win_ce_count", 64'(ce_count), 64'd0);
    chk("clr_win_ue_count", 64'(ue_count), 64'd0);
    drain("drain_clear");

    // Reset with two words in flight: none may appear afterwards.
    @(negedge clk);
    out_ready = 1'b0;
    send(enc(32'hBAD0BAD0), '0, 0);
    send(enc(32'hBAD1BAD1), '0, 0);
    idle();
    #2;
    chk("inflight_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    out_before = n_out;
    #2;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_data_out", 64'(data_out), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(negedge clk);
    #2;
    chk("post_rst_no_words", 64'(n_out - out_before), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
